// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the dual-write-port register file: arbitrates ALU/div/load/ext writes
// onto ports B (dst) and A (src). Optional long-latency scoreboard enabled by REGWB_SCOREBOARD_EN.
module regfile_wb_sched #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 6,
  parameter int unsigned EXT_AGE = 8
) (
  input  logic          sys_clk,
  input  logic          reset_n,
  input  logic          clk_en,
  input  logic          alu_req,
  input  logic [AW-1:0] alu_a,
  input  logic [DW-1:0] alu_d,
  input  logic          div_req,
  input  logic          ld_req,
  input  logic          ext_req,
  input  logic [AW-1:0] div_a,
  input  logic [AW-1:0] ld_a,
  input  logic [AW-1:0] ext_a,
  input  logic [DW-1:0] div_d,
  input  logic [DW-1:0] ld_d,
  input  logic [DW-1:0] ext_d,
  output logic          div_ack,
  output logic          ld_ack,
  output logic          ext_ack,
  input  logic          iss_pend,
  input  logic [AW-1:0] iss_pa,
  input  logic          rd_use,
  input  logic [AW-1:0] rd_srca,
  input  logic [AW-1:0] rd_dsta,
  output logic          srcrwen_n,
  output logic [AW-1:0] srca_w,
  output logic [DW-1:0] srcwd,
  output logic          dstrwen_n,
  output logic [AW-1:0] dsta_w,
  output logic [DW-1:0] dstwd,
  output logic          stall,
  output logic          sb_busy
);

  localparam int unsigned AgeW = $clog2(EXT_AGE + 1);

  // Requester indices: 0 alu, 1 div, 2 ld, 3 ext.
  logic [3:0]    req;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] data [4];
  logic [1:0]    ord  [4];
  logic          ext_first;
  logic          found1, found2;
  logic [1:0]    c1, c2;
  logic [3:0]    grant;

  logic          dst_wen_n_q, dst_wen_n_d, src_wen_n_q, src_wen_n_d;
  logic [AW-1:0] dsta_q, dsta_d, srca_q, srca_d;
  logic [DW-1:0] dstwd_q, dstwd_d, srcwd_q, srcwd_d;
  logic [2:0]    ack_q, ack_d;
  logic [AgeW-1:0] age_q, age_d;

  assign req = {ext_req, ld_req, div_req, alu_req};

  always_comb begin
    addr[0] = alu_a;
    addr[1] = div_a;
    addr[2] = ld_a;
    addr[3] = ext_a;
    data[0] = alu_d;
    data[1] = div_d;
    data[2] = ld_d;
    data[3] = ext_d;
  end

  assign ext_first = (age_q >= AgeW'(EXT_AGE));

  always_comb begin
    ord[0] = 2'd0;
    ord[1] = 2'd1;
    ord[2] = ext_first ? 2'd3 : 2'd2;
    ord[3] = ext_first ? 2'd2 : 2'd3;
  end

  // Pick the two highest-priority requesters; the second loses on address collision and the
  // freed slot is deliberately left empty for this edge.
  always_comb begin
    found1 = 1'b0;
    found2 = 1'b0;
    c1     = 2'd0;
    c2     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (req[ord[i]]) begin
        if (!found1) begin
          found1 = 1'b1;
          c1     = ord[i];
        end else if (!found2) begin
          found2 = 1'b1;
          c2     = ord[i];
        end
      end
    end
    if (found2 && (addr[c1] == addr[c2])) found2 = 1'b0;
    grant = 4'b0000;
    if (found1) grant[c1] = 1'b1;
    if (found2) grant[c2] = 1'b1;
  end

  always_comb begin
    dst_wen_n_d = dst_wen_n_q;
    src_wen_n_d = src_wen_n_q;
    dsta_d      = dsta_q;
    srca_d      = srca_q;
    dstwd_d     = dstwd_q;
    srcwd_d     = srcwd_q;
    age_d       = age_q;
    ack_d       = 3'b000;
    if (clk_en) begin
      dst_wen_n_d = ~found1;
      src_wen_n_d = ~found2;
      if (found1) begin
        dsta_d  = addr[c1];
        dstwd_d = data[c1];
      end
      if (found2) begin
        srca_d  = addr[c2];
        srcwd_d = data[c2];
      end
      ack_d = {grant[1], grant[2], grant[3]};
      if (ext_req && !grant[3]) begin
        age_d = (age_q == AgeW'(EXT_AGE)) ? age_q : age_q + 1'b1;
      end else begin
        age_d = '0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      dst_wen_n_q <= 1'b1;
      src_wen_n_q <= 1'b1;
      dsta_q      <= '0;
      srca_q      <= '0;
      dstwd_q     <= '0;
      srcwd_q     <= '0;
      ack_q       <= 3'b000;
      age_q       <= '0;
    end else begin
      dst_wen_n_q <= dst_wen_n_d;
      src_wen_n_q <= src_wen_n_d;
      dsta_q      <= dsta_d;
      srca_q      <= srca_d;
      dstwd_q     <= dstwd_d;
      srcwd_q     <= srcwd_d;
      ack_q       <= ack_d;
      age_q       <= age_d;
    end
  end

  assign dstrwen_n = dst_wen_n_q;
  assign srcrwen_n = src_wen_n_q;
  assign dsta_w    = dsta_q;
  assign srca_w    = srca_q;
  assign dstwd     = dstwd_q;
  assign srcwd     = srcwd_q;
  assign div_ack   = ack_q[2];
  assign ld_ack    = ack_q[1];
  assign ext_ack   = ack_q[0];

`ifdef REGWB_SCOREBOARD_EN
  logic [2**AW-1:0] sb_q, sb_d, sb_set, sb_clr;
  logic             sb_busy_q, sb_busy_d;

  // Set is applied after clear so a same-edge issue to a retiring register keeps the bit.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (iss_pend) sb_set[iss_pa] = 1'b1;
    if (grant[1]) sb_clr[div_a] = 1'b1;
    if (grant[2]) sb_clr[ld_a]  = 1'b1;
    sb_d      = sb_q;
    sb_busy_d = sb_busy_q;
    if (clk_en) begin
      sb_d      = (sb_q & ~sb_clr) | sb_set;
      sb_busy_d = |sb_d;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_q      <= '0;
      sb_busy_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      sb_busy_q <= sb_busy_d;
    end
  end

  assign stall   = rd_use & (sb_q[rd_srca] | sb_q[rd_dsta]);
  assign sb_busy = sb_busy_q;
`else
  logic unused_sb;
  assign unused_sb = ^{iss_pend, iss_pa, rd_use, rd_srca, rd_dsta};
  assign stall     = 1'b0;
  assign sb_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: expected port writes/acks are queued when stimulus is
// driven and compared after the next clock edge; scoreboard checks follow REGWB_SCOREBOARD_EN.
module tb_regfile_wb_sched;

`ifdef REGWB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        reset_n, clk_en;
  logic        alu_req, div_req, ld_req, ext_req;
  logic [5:0]  alu_a, div_a, ld_a, ext_a;
  logic [31:0] alu_d, div_d, ld_d, ext_d;
  logic        div_ack, ld_ack, ext_ack;
  logic        iss_pend, rd_use;
  logic [5:0]  iss_pa, rd_srca, rd_dsta;
  logic        srcrwen_n, dstrwen_n, stall, sb_busy;
  logic [5:0]  srca_w, dsta_w;
  logic [31:0] srcwd, dstwd;

  always #5 sys_clk = ~sys_clk;

  regfile_wb_sched dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .clk_en(clk_en),
    .alu_req(alu_req), .alu_a(alu_a), .alu_d(alu_d),
    .div_req(div_req), .ld_req(ld_req), .ext_req(ext_req),
    .div_a(div_a), .ld_a(ld_a), .ext_a(ext_a),
    .div_d(div_d), .ld_d(ld_d), .ext_d(ext_d),
    .div_ack(div_ack), .ld_ack(ld_ack), .ext_ack(ext_ack),
    .iss_pend(iss_pend), .iss_pa(iss_pa),
    .rd_use(rd_use), .rd_srca(rd_srca), .rd_dsta(rd_dsta),
    .srcrwen_n(srcrwen_n), .srca_w(srca_w), .srcwd(srcwd),
    .dstrwen_n(dstrwen_n), .dsta_w(dsta_w), .dstwd(dstwd),
    .stall(stall), .sb_busy(sb_busy)
  );

  typedef struct {
    string       tag;
    logic        bwn;
    logic [5:0]  ba;
    logic [31:0] bd;
    logic        awn;
    logic [5:0]  aa;
    logic [31:0] ad;
    logic [2:0]  ack;  // {div, ld, ext}
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic bwn, input logic [5:0] ba,
                      input logic [31:0] bd, input logic awn, input logic [5:0] aa,
                      input logic [31:0] ad, input logic [2:0] ack);
    exp_t e;
    e.tag = tag; e.bwn = bwn; e.ba = ba; e.bd = bd;
    e.awn = awn; e.aa = aa; e.ad = ad; e.ack = ack;
    q.push_back(e);
  endtask

  task automatic idle(input string tag);
    push(tag, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 32'd0, 3'b000);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge sys_clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".dstrwen_n"}, 64'(dstrwen_n), 64'(e.bwn));
      chk({e.tag, ".srcrwen_n"}, 64'(srcrwen_n), 64'(e.awn));
      if (!e.bwn) begin
        chk({e.tag, ".dsta_w"}, 64'(dsta_w), 64'(e.ba));
        chk({e.tag, ".dstwd"}, 64'(dstwd), 64'(e.bd));
      end
      if (!e.awn) begin
        chk({e.tag, ".srca_w"}, 64'(srca_w), 64'(e.aa));
        chk({e.tag, ".srcwd"}, 64'(srcwd), 64'(e.ad));
      end
      chk({e.tag, ".acks"}, 64'({div_ack, ld_ack, ext_ack}), 64'(e.ack));
    end
  endtask

  initial begin
    reset_n = 1'b0; clk_en = 1'b1;
    alu_req = 1'b1; alu_a = 6'd5; alu_d = 32'h11;
    div_req = 1'b1; div_a = 6'd7; div_d = 32'h22;
    ld_req  = 1'b1; ld_a  = 6'd3; ld_d  = 32'h33;
    ext_req = 1'b1; ext_a = 6'd4; ext_d = 32'h44;
    iss_pend = 1'b0; iss_pa = '0; rd_use = 1'b0; rd_srca = '0; rd_dsta = '0;

    // Held in reset with every request high: nothing may be written or acked.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst.dstrwen_n", 64'(dstrwen_n), 64'd1);
      chk("rst.srcrwen_n", 64'(srcrwen_n), 64'd1);
      chk("rst.acks", 64'({div_ack, ld_ack, ext_ack}), 64'd0);
      chk("rst.addr", 64'({dsta_w, srca_w}), 64'd0);
      chk("rst.data", 64'({dstwd, srcwd}), 64'd0);
      chk("rst.sb_busy", 64'(sb_busy), 64'd0);
    end
    reset_n = 1'b1;

    push("first", 1'b0, 6'd5, 32'h11, 1'b0, 6'd7, 32'h22, 3'b100);
    cyc();
    alu_req = 1'b0; div_req = 1'b0;
    push("ld_ext", 1'b0, 6'd3, 32'h33, 1'b0, 6'd4, 32'h44, 3'b011);
    cyc();
    ld_req = 1'b0; ext_req = 1'b0;

    // Address collision: alu wins, div waits one edge.
    alu_req = 1'b1; alu_a = 6'd9; alu_d = 32'h55;
    div_req = 1'b1; div_a = 6'd9; div_d = 32'h66;
    push("coll", 1'b0, 6'd9, 32'h55, 1'b1, 6'd0, 32'd0, 3'b000);
    cyc();
    alu_req = 1'b0;
    push("coll_div", 1'b0, 6'd9, 32'h66, 1'b1, 6'd0, 32'd0, 3'b100);
    cyc();
    div_req = 1'b0;

    // Collision with a third requester: ld is not promoted into the freed slot.
    alu_req = 1'b1; alu_a = 6'd14; alu_d = 32'h70;
    div_req = 1'b1; div_a = 6'd14; div_d = 32'h71;
    ld_req  = 1'b1; ld_a  = 6'd15; ld_d  = 32'h72;
    push("coll3", 1'b0, 6'd14, 32'h70, 1'b1, 6'd0, 32'd0, 3'b000);
    cyc();
    alu_req = 1'b0;
    push("coll3_next", 1'b0, 6'd14, 32'h71, 1'b0, 6'd15, 32'h72, 3'b110);
    cyc();
    div_req = 1'b0; ld_req = 1'b0;

    // Ext aging: ld beats ext for 8 edges, then ext is promoted ahead of ld.
    alu_req = 1'b1; alu_a = 6'd10;
    ld_req  = 1'b1; ld_a  = 6'd11; ld_d  = 32'hB0;
    ext_req = 1'b1; ext_a = 6'd12; ext_d = 32'hE0;
    for (int k = 0; k < 8; k++) begin
      alu_d = 32'(k);
      push("age_ld", 1'b0, 6'd10, 32'(k), 1'b0, 6'd11, 32'hB0, 3'b010);
      cyc();
    end
    alu_d = 32'd8;
    push("age_ext", 1'b0, 6'd10, 32'd8, 1'b0, 6'd12, 32'hE0, 3'b001);
    cyc();
    ext_req = 1'b0; alu_d = 32'd9;
    push("age_ld_again", 1'b0, 6'd10, 32'd9, 1'b0, 6'd11, 32'hB0, 3'b010);
    cyc();
    alu_req = 1'b0; ld_req = 1'b0;
    idle("idle0");
    cyc();

    // clk_en low: ports hold, ack is a single pulse.
    div_req = 1'b1; div_a = 6'd20; div_d = 32'h77;
    push("div_solo", 1'b0, 6'd20, 32'h77, 1'b1, 6'd0, 32'd0, 3'b100);
    cyc();
    div_req = 1'b0; clk_en = 1'b0;
    push("hold", 1'b0, 6'd20, 32'h77, 1'b1, 6'd0, 32'd0, 3'b000);
    cyc();
    clk_en = 1'b1;
    idle("idle1");
    cyc();

    // Scoreboard: set, hazard, clear by ld grant, same-edge set wins.
    iss_pend = 1'b1; iss_pa = 6'd12;
    idle("iss");
    cyc();
    iss_pend = 1'b0;
    rd_use = 1'b1; rd_srca = 6'd12; rd_dsta = 6'd3;
    #1;
    chk("sb.stall_src", 64'(stall), 64'(SB));
    chk("sb.busy", 64'(sb_busy), 64'(SB));
    rd_srca = 6'd5; rd_dsta = 6'd12;
    #1;
    chk("sb.stall_dst", 64'(stall), 64'(SB));
    rd_use = 1'b0;
    #1;
    chk("sb.no_use", 64'(stall), 64'd0);
    rd_use = 1'b1; rd_srca = 6'd12;
    ld_req = 1'b1; ld_a = 6'd12; ld_d = 32'hC1;
    push("sb_ld", 1'b0, 6'd12, 32'hC1, 1'b1, 6'd0, 32'd0, 3'b010);
    cyc();
    ld_req = 1'b0;
    chk("sb.cleared_stall", 64'(stall), 64'd0);
    chk("sb.cleared_busy", 64'(sb_busy), 64'd0);
    iss_pend = 1'b1; iss_pa = 6'd12;
    idle("iss2");
    cyc();
    ld_req = 1'b1; ld_a = 6'd12; ld_d = 32'hC2;
    push("sb_same_edge", 1'b0, 6'd12, 32'hC2, 1'b1, 6'd0, 32'd0, 3'b010);
    cyc();
    ld_req = 1'b0; iss_pend = 1'b0;
    chk("sb.set_wins_stall", 64'(stall), 64'(SB));
    chk("sb.set_wins_busy", 64'(sb_busy), 64'(SB));
    ld_req = 1'b1; ld_d = 32'hC3;
    push("sb_ld2", 1'b0, 6'd12, 32'hC3, 1'b1, 6'd0, 32'd0, 3'b010);
    cyc();
    ld_req = 1'b0;
    chk("sb.final_stall", 64'(stall), 64'd0);
    chk("sb.final_busy", 64'(sb_busy), 64'd0);

    // Reset mid-operation discards pending grants.
    div_req = 1'b1; div_a = 6'd30; div_d = 32'h99;
    #2;
    reset_n = 1'b0;
    cyc();
    chk("midrst.dstrwen_n", 64'(dstrwen_n), 64'd1);
    chk("midrst.acks", 64'({div_ack, ld_ack, ext_ack}), 64'd0);
    div_req = 1'b0; reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
